// File: rtl/k_rev_extend.sv
// Inverse AES-128 key schedule: takes the round-10 key and steps backwards one
// round per cycle, streaming round keys 10..0 (or only round 0) over valid/ready.
module k_rev_extend #(
    parameter bit EMIT_ALL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, STEP, EMIT, DONE} state_t;

    state_t       state, state_nx;
    logic [127:0] key_reg, key_nx, key_prev;
    logic [3:0]   round, round_nx;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the field inverse with 0 -> 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One inverse round: recover words b..d by XOR, then word a through g(d', r).
    logic [31:0] wa, wb, wc, wd, nd, rot, g_out;

    always_comb begin
        {wa, wb, wc, wd} = key_reg;
        nd       = wc ^ wd;
        rot      = {nd[23:0], nd[31:24]};
        g_out    = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon(round), 24'h0};
        key_prev = {wa ^ g_out, wa ^ wb, wb ^ wc, nd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_reg <= '0;
            round   <= '0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state   <= state_nx;
            key_reg <= key_nx;
            round   <= round_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first; a path that
        // skips an assignment would otherwise infer a latch.
        state_nx = state;
        key_nx   = key_reg;
        round_nx = round;
        rk_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    key_nx   = key_in;
                    round_nx = 4'd10;
                    state_nx = EMIT_ALL ? EMIT : STEP;
                end
            end
            STEP: begin
                busy     = 1'b1;
                key_nx   = key_prev;
                round_nx = round - 4'd1;
                if (round == 4'd1) state_nx = EMIT;
            end
            EMIT: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (round != 4'd0) begin
                        key_nx   = key_prev;
                        round_nx = round - 4'd1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Key register doubles as the output so rk_out holds its last value when idle.
    assign rk_out = key_reg;
    assign rk_idx = round;

endmodule

// File: tb/tb_k_rev_extend.sv
// Self-checking bench for k_rev_extend: FIPS-197 vectors, backpressure, ignored
// restarts, mid-stream reset and round trips against a forward expansion model.
module tb_k_rev_extend;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         start_a, ready_a, start_b, ready_b;
    logic [127:0] rk_out_a, rk_out_b;
    logic [3:0]   rk_idx_a, rk_idx_b;
    logic         rk_valid_a, rk_valid_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    k_rev_extend #(.EMIT_ALL(1'b1)) dut_all (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_in),
        .rk_out(rk_out_a), .rk_idx(rk_idx_a), .rk_valid(rk_valid_a),
        .rk_ready(ready_a), .busy(busy_a), .done(done_a)
    );

    k_rev_extend #(.EMIT_ALL(1'b0)) dut_k0 (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_in),
        .rk_out(rk_out_b), .rk_idx(rk_idx_b), .rk_valid(rk_valid_b),
        .rk_ready(ready_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Forward key expansion model with its own S-box built by the 3-generator walk.
    logic [7:0]   sb [0:255];
    logic [127:0] mk [0:10];
    logic [127:0] beats [0:10];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sb[p] = x;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = ck;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Full EMIT_ALL=1 run from cipher key ck; round-10 key of the model is fed in.
    task automatic run_all(input logic [127:0] ck, input bit rand_ready);
        int n_beats, cyc;
        bit stalled;
        logic [127:0] held_rk;
        logic [3:0] held_idx;
        expand(ck);
        @(negedge clk);
        start_a = 1'b1;
        key_in  = mk[10];
        @(negedge clk);
        start_a = 1'b0;
        key_in  = ~mk[10];
        cyc = 1;
        n_beats = 0;
        stalled = 1'b0;
        while (n_beats < 11 && cyc < 300) begin
            check("valid_in_emit", 128'(rk_valid_a), 128'(1'b1));
            check("busy_in_emit", 128'(busy_a), 128'(1'b1));
            check("idx_seq", 128'(rk_idx_a), 128'(10 - n_beats));
            check("rk_value", rk_out_a, mk[10 - n_beats]);
            if (stalled) begin
                check("stall_hold_rk", rk_out_a, held_rk);
                check("stall_hold_idx", 128'(rk_idx_a), 128'(held_idx));
            end
            if (!rand_ready) check("beat_latency", 128'(cyc), 128'(n_beats + 1));
            // A second start with a different key mid-stream must be ignored.
            start_a = (cyc == 3);
            if (cyc == 3) key_in = mk[5] ^ 128'h1;
            ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready_a && rk_valid_a) begin
                beats[rk_idx_a] = rk_out_a;
                n_beats++;
            end
            stalled  = !ready_a;
            held_rk  = rk_out_a;
            held_idx = rk_idx_a;
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        ready_a = 1'b0;
        if (cyc >= 300) check("stream_timeout", 128'(n_beats), 128'd11);
        check("done_pulse", 128'(done_a), 128'(1'b1));
        check("done_valid_low", 128'(rk_valid_a), 128'(1'b0));
        check("done_busy_low", 128'(busy_a), 128'(1'b0));
        check("done_rk_kept", rk_out_a, mk[0]);
        if (!rand_ready) check("done_latency", 128'(cyc), 128'd12);
    endtask

    typedef struct {
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        vecs[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        build_sbox();
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0;
        start_b = 1'b0; ready_b = 1'b0;
        key_in = '0;
        repeat (2) @(negedge clk);
        check("rst_rk_out", rk_out_a, 128'h0);
        check("rst_rk_idx", 128'(rk_idx_a), 128'h0);
        check("rst_valid", 128'(rk_valid_a), 128'h0);
        check("rst_busy", 128'(busy_a), 128'h0);
        check("rst_done", 128'(done_a), 128'h0);
        check("rst_k0_all", {rk_out_b, rk_idx_b, rk_valid_b, busy_b, done_b}, '0);
        rst = 1'b0;

        // FIPS-197 A.1, ready tied high, checked against the table.
        run_all(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("fips_idx%0d", vecs[i].idx), beats[vecs[i].idx], vecs[i].rk);

        // Back-to-back start in the cycle after done, then random backpressure.
        run_all(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        for (int i = 0; i < 4; i++)
            check($sformatf("fips_rand_idx%0d", vecs[i].idx), beats[vecs[i].idx], vecs[i].rk);

        // EMIT_ALL=0: ten silent steps, one idx0 beat at t+11, stalled once.
        @(negedge clk);
        start_b = 1'b1;
        key_in  = vecs[0].rk;
        @(negedge clk);
        start_b = 1'b0;
        key_in  = '0;
        for (int c = 1; c <= 10; c++) begin
            check("k0_step_silent", 128'(rk_valid_b), 128'(1'b0));
            check("k0_step_busy", 128'(busy_b), 128'(1'b1));
            @(negedge clk);
        end
        check("k0_valid_t11", 128'(rk_valid_b), 128'(1'b1));
        check("k0_idx0", 128'(rk_idx_b), 128'h0);
        check("k0_rk0", rk_out_b, vecs[3].rk);
        @(negedge clk);
        check("k0_stall_hold", {rk_out_b, rk_idx_b, rk_valid_b}, {vecs[3].rk, 4'd0, 1'b1});
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        check("k0_done", 128'({done_b, busy_b, rk_valid_b}), 128'(3'b100));

        // Reset while stalled on idx5 aborts to reset values.
        expand(128'h000102030405060708090a0b0c0d0e0f);
        @(negedge clk);
        start_a = 1'b1;
        key_in  = mk[10];
        @(negedge clk);
        start_a = 1'b0;
        ready_a = 1'b1;
        repeat (5) @(negedge clk);
        ready_a = 1'b0;
        @(negedge clk);
        check("pre_rst_idx5", 128'(rk_idx_a), 128'd5);
        check("pre_rst_rk5", rk_out_a, mk[5]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_all", {rk_out_a, rk_idx_a, rk_valid_a, busy_a, done_a}, '0);
        run_all(128'h000102030405060708090a0b0c0d0e0f, 1'b0);

        // Round trip against the forward expansion on random cipher keys.
        for (int k = 0; k < 100; k++) begin
            run_all({$urandom, $urandom, $urandom, $urandom}, 1'(k % 2));
            for (int r = 0; r <= 10; r++) check("roundtrip", beats[r], mk[r]);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
